// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: 4-channel round-robin arbiter driving a 4:1 data mux.
// A requester keeps the grant for at most MAX_HOLD consecutive cycles while
// others wait. Grant, mux select and the last-grant pointer are all registered.
module mux4_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    input  logic [1:0] d,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic [1:0] y,
    output logic       y_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_lp;
    logic [3:0] r_hold;

    logic [3:0] w_cur_oh;
    logic [3:0] w_others;
    logic       w_cur_req;
    logic       w_load;
    logic       w_release;
    logic [1:0] w_next_idx;

    // First requester in the order lp+1, lp+2, lp+3, lp (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-grant decision: whether to load a new winner or release to idle.
    // In BUSY the current holder is always r_lp, so no separate index register.
    always_comb begin
        w_cur_oh   = 4'b0001 << r_lp;
        w_others   = req & ~w_cur_oh;
        w_cur_req  = |(req & w_cur_oh);
        w_load     = 1'b0;
        w_release  = 1'b0;
        w_next_idx = rr_pick(req, r_lp);
        if (r_state == ST_IDLE) begin
            w_load = |req;
        end else begin
            if (!w_cur_req || (r_hold == HOLD_LAST)) begin
                w_next_idx = rr_pick(w_others, r_lp);
                w_load     = |w_others;
            end
            w_release = !w_cur_req && !(|w_others);
        end
    end

    // Arbitration FSM with registered grant, select, pointer and hold count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            gnt     <= '0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            r_hold  <= '0;
            r_lp    <= 2'd3;
        end else if (w_load) begin
            r_state <= ST_BUSY;
            gnt     <= 4'b0001 << w_next_idx;
            s0      <= w_next_idx[1];
            s1      <= w_next_idx[0];
            r_hold  <= '0;
            r_lp    <= w_next_idx;
        end else if (w_release) begin
            r_state <= ST_IDLE;
            gnt     <= '0;
            r_hold  <= '0;
        end else if (r_state == ST_BUSY && r_hold != HOLD_LAST) begin
            r_hold  <= r_hold + 4'd1;
        end
    end

    // Output mux: selected channel data, forced to zero when nothing is granted.
    always_comb begin
        y_valid = |gnt;
        y       = '0;
        if (y_valid) begin
            case ({s0, s1})
                2'b00:   y = a;
                2'b01:   y = b;
                2'b10:   y = c;
                default: y = d;
            endcase
        end
    end

endmodule

// File: doc/mux4_rr_scheduler.md
MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

Interface
REQ-001 Parameter MAX_HOLD, default 4, is the maximum consecutive cycles one requester keeps the grant while others wait (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per channel; bit i belongs to channel i.
REQ-005 a, b, c, d  input  2 each  data of channels 0, 1, 2, 3.
REQ-006 gnt  output  4  registered one-hot grant; all zero when idle.
REQ-007 s0, s1  output  1 each  registered mux select: {s0,s1} = granted index (00=a, 01=b, 10=c, 11=d).
REQ-008 y  output  2  selected channel data.
REQ-009 y_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-010 The block shall implement a two-state FSM: IDLE (gnt=0) and BUSY (one gnt bit set).
REQ-011 The block shall keep a 2-bit last-grant pointer, lp; priority order is lp+1, lp+2, lp+3, lp (mod 4).
REQ-012 In IDLE, if req!=0, the block shall at the next edge grant the highest-priority requester, set lp to it, load hold_cnt=0 and enter BUSY; if req==0 it shall stay in IDLE.
REQ-013 In BUSY, if req[cur]=0 and other requests exist, the block shall grant the next RR winner among the other channels at the next edge, with hold_cnt=0 and no idle cycle.
REQ-014 In BUSY, if req[cur]=0 and no other request exists, the block shall enter IDLE at the next edge with gnt=0.
REQ-015 In BUSY, if req[cur]=1 and hold_cnt=MAX_HOLD-1 and any other request exists, the block shall rotate the grant to the next RR winner (excluding cur) and load hold_cnt=0.
REQ-016 In BUSY, if req[cur]=1 and the rotation condition is false, the block shall keep the grant, with hold_cnt incrementing and saturating at MAX_HOLD-1.
REQ-017 Grant latency shall be exactly one cycle from req sampled high to gnt high; release latency shall be one cycle from req dropping.
REQ-018 y shall be a combinational function of {s0,s1} and a..d; y shall be 2'b00 when y_valid=0.
REQ-019 s0, s1 shall update on the same edge as gnt and hold their last value while IDLE.
REQ-020 Simultaneous requests on all four channels shall be served in strict rotation; no channel shall wait more than 3*MAX_HOLD cycles once its req is high.
REQ-021 gnt shall never have more than one bit set in any cycle.

Reset
REQ-022 While rst_n=0 the block shall immediately force state=IDLE, gnt=0, s0=s1=0, y=0, y_valid=0, hold_cnt=0, and lp=3 (channel 0 has first priority).
REQ-023 Reset asserted mid-grant shall drop gnt asynchronously, without waiting for a clock edge.
REQ-024 After reset release, arbitration shall resume at the first rising edge with rst_n=1.

Verification
REQ-025 Reset, then req=4'b0001 with a=2'b01 -> next edge: gnt=0001, {s0,s1}=00, y=01, y_valid=1.
REQ-026 req=4'b1111 held with MAX_HOLD=4 -> gnt is 0001 for 4 cycles, then 0010, 0100 and 1000 for 4 cycles each, then 0001 again.
REQ-027 Channel 2 is granted and drops req while req=4'b1001 -> next edge gnt=1000 with no idle cycle; if instead req=0 -> next edge gnt=0, y_valid=0, y=00.
REQ-028 A single requester, channel 3, is held for 20 cycles with d=2'b11 -> gnt=1000 throughout, y=11, and no rotation.
REQ-029 rst_n pulled low mid-cycle while gnt=0100 -> gnt=0 and y_valid=0 before the next edge; after release with req=4'b0110 -> gnt=0010.
REQ-030 Random req for 10k cycles -> gnt is always one-hot or zero, and every waiting channel is served within 3*MAX_HOLD cycles.
